// File: rtl/chip8_pkg.sv
// Shared types for the chip8 memory subsystem: arbiter FSM states and requester ids.
package chip8_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    READ_WAIT = 2'd2
  } arb_state_e;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DMA = 1'b1
  } req_id_e;

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester (cpu/dma) arbiter in front of a memory with a 1-cycle synchronous read port.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is cpu priority with a dma starvation guard.
module mem_arbiter
  import chip8_pkg::*;
#(
  parameter int unsigned ADDR_W       = 12,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              fpga_clk,
  input  logic              rst_in,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic              cpu_rvalid,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_wr_go,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data
);

  arb_state_e        state;
  arb_state_e        state_next;
  req_id_e           grant_id;
  req_id_e           cap_id;
  logic              cap_we;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;
  logic              any_req;
  logic              arb_go;

  assign any_req = cpu_req | dma_req;
  assign arb_go  = (state == IDLE) && any_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  req_id_e last_id;

  // On contention the requester not served last wins; a lone requester always wins.
  always_comb begin
    grant_id = REQ_CPU;
    if (cpu_req && dma_req) begin
      grant_id = (last_id == REQ_CPU) ? REQ_DMA : REQ_CPU;
    end else if (dma_req) begin
      grant_id = REQ_DMA;
    end
  end

  // Reset to dma so the first contended grant goes to cpu.
  always_ff @(posedge fpga_clk or posedge rst_in) begin
    if (rst_in) begin
      last_id <= REQ_DMA;
    end else if (arb_go) begin
      last_id <= grant_id;
    end
  end
`else
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 2);

  logic [CNT_W-1:0] starve_cnt;
  logic             starved;

  assign starved = (starve_cnt >= CNT_W'(STARVE_LIMIT));

  always_comb begin
    grant_id = REQ_CPU;
    if (dma_req && (!cpu_req || starved)) begin
      grant_id = REQ_DMA;
    end
  end

  // Counts arbitrations dma lost while requesting; saturates at the limit until dma is served.
  always_ff @(posedge fpga_clk or posedge rst_in) begin
    if (rst_in) begin
      starve_cnt <= '0;
    end else if (arb_go) begin
      if (grant_id == REQ_DMA) begin
        starve_cnt <= '0;
      end else if (dma_req && !starved) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end
  end
`endif

  always_ff @(posedge fpga_clk or posedge rst_in) begin
    if (rst_in) begin
      cap_id    <= REQ_CPU;
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
    end else if (arb_go) begin
      cap_id <= grant_id;
      if (grant_id == REQ_DMA) begin
        cap_we    <= dma_we;
        cap_addr  <= dma_addr;
        cap_wdata <= dma_wdata;
      end else begin
        cap_we    <= cpu_we;
        cap_addr  <= cpu_addr;
        cap_wdata <= cpu_wdata;
      end
    end
  end

  always_ff @(posedge fpga_clk or posedge rst_in) begin
    if (rst_in) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Outputs decode purely from state and captured values, so reset clears them immediately.
  always_comb begin
    state_next  = state;
    cpu_ack     = 1'b0;
    dma_ack     = 1'b0;
    cpu_rvalid  = 1'b0;
    dma_rvalid  = 1'b0;
    rdata       = '0;
    mem_wr_go   = 1'b0;
    mem_wr_addr = '0;
    mem_wr_data = '0;
    mem_rd_addr = '0;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        cpu_ack     = (cap_id == REQ_CPU);
        dma_ack     = (cap_id == REQ_DMA);
        mem_rd_addr = cap_addr;
        mem_wr_addr = cap_addr;
        if (cap_we) begin
          mem_wr_go   = 1'b1;
          mem_wr_data = cap_wdata;
          state_next  = IDLE;
        end else begin
          state_next  = READ_WAIT;
        end
      end
      READ_WAIT: begin
        cpu_rvalid = (cap_id == REQ_CPU);
        dma_rvalid = (cap_id == REQ_DMA);
        rdata      = mem_rd_data;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table of single accesses plus contention, reset and capture sequences.
module tb_mem_arbiter;

  logic        fpga_clk;
  logic        rst_in;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [11:0] cpu_addr, dma_addr;
  logic [7:0]  cpu_wdata, dma_wdata;
  logic        cpu_ack, cpu_rvalid, dma_ack, dma_rvalid;
  logic [7:0]  rdata;
  logic        mem_wr_go;
  logic [11:0] mem_wr_addr, mem_rd_addr;
  logic [7:0]  mem_wr_data, mem_rd_data;

  int vectors;
  int miscompares;

  mem_arbiter #(
    .ADDR_W(12),
    .DATA_W(8),
    .STARVE_LIMIT(4)
  ) dut (
    .fpga_clk(fpga_clk),
    .rst_in(rst_in),
    .cpu_req(cpu_req),
    .cpu_we(cpu_we),
    .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack),
    .cpu_rvalid(cpu_rvalid),
    .dma_req(dma_req),
    .dma_we(dma_we),
    .dma_addr(dma_addr),
    .dma_wdata(dma_wdata),
    .dma_ack(dma_ack),
    .dma_rvalid(dma_rvalid),
    .rdata(rdata),
    .mem_wr_go(mem_wr_go),
    .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data),
    .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data)
  );

  initial fpga_clk = 1'b0;
  always #5 fpga_clk = ~fpga_clk;

  // Memory: mem[a] = a[7:0]^0x3C, except mem[0x200] = 0xA2; reloaded while reset is high.
  logic [7:0] mem [0:4095];
  always @(posedge fpga_clk) begin
    if (rst_in) begin
      for (int unsigned i = 0; i < 4096; i++) mem[i] <= 8'(i) ^ 8'h3C;
      mem[12'h200] <= 8'hA2;
    end else if (mem_wr_go) begin
      mem[mem_wr_addr] <= mem_wr_data;
    end
    mem_rd_data <= mem[mem_rd_addr];
  end

  typedef struct {
    logic        dma;
    logic        we;
    logic [11:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  exp_rdata;
  } vec_t;

  vec_t vecs [7];

  function automatic logic [63:0] all_outs();
    return {19'b0, cpu_ack, dma_ack, cpu_rvalid, dma_rvalid, mem_wr_go,
            rdata, mem_wr_addr, mem_wr_data, mem_rd_addr};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
  endtask

  // Called at a negedge with the DUT in IDLE; returns at a negedge with the DUT back in IDLE.
  task automatic run_vec(input vec_t v);
    if (v.dma) begin
      dma_req = 1'b1; dma_we = v.we; dma_addr = v.addr; dma_wdata = v.wdata;
    end else begin
      cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
    end
    check("idle_acks", {62'b0, cpu_ack, dma_ack}, 64'd0);
    @(negedge fpga_clk);
    check("ack", {62'b0, cpu_ack, dma_ack}, v.dma ? 64'd1 : 64'd2);
    check("wr_go", {63'b0, mem_wr_go}, {63'b0, v.we});
    check("issue_rdata", {54'b0, cpu_rvalid, dma_rvalid, rdata}, 64'd0);
    if (v.we) check("wr_port", {44'b0, mem_wr_addr, mem_wr_data}, {44'b0, v.addr, v.wdata});
    else      check("rd_addr", {52'b0, mem_rd_addr}, {52'b0, v.addr});
    idle_inputs();
    @(negedge fpga_clk);
    if (!v.we) begin
      check("rvalid_rdata", {54'b0, cpu_rvalid, dma_rvalid, rdata},
            {54'b0, ~v.dma, v.dma, v.exp_rdata});
      @(negedge fpga_clk);
    end
  endtask

  initial begin
    int        ng;
    logic      grants [10];
    logic      exp_g;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   ng;
    logic grants [10];
    logic exp_g;
    vectors = 0;
    miscompares = 0;

    vecs[0] = '{dma: 1'b0, we: 1'b0, addr: 12'h200, wdata: 8'h00, exp_rdata: 8'hA2};
    vecs[1] = '{dma: 1'b1, we: 1'b1, addr: 12'h050, wdata: 8'hF0, exp_rdata: 8'h00};
    vecs[2] = '{dma: 1'b1, we: 1'b0, addr: 12'h050, wdata: 8'h00, exp_rdata: 8'hF0};
    vecs[3] = '{dma: 1'b0, we: 1'b1, addr: 12'hFFF, wdata: 8'h5A, exp_rdata: 8'h00};
    vecs[4] = '{dma: 1'b0, we: 1'b0, addr: 12'hFFF, wdata: 8'h00, exp_rdata: 8'h5A};
    vecs[5] = '{dma: 1'b1, we: 1'b0, addr: 12'h000, wdata: 8'h00, exp_rdata: 8'h3C};
    vecs[6] = '{dma: 1'b0, we: 1'b0, addr: 12'h123, wdata: 8'h00, exp_rdata: 8'h1F};

    idle_inputs();
    rst_in = 1'b1;
    repeat (3) @(negedge fpga_clk);
    check("reset_outputs", all_outs(), 64'd0);
    rst_in = 1'b0;

    foreach (vecs[k]) run_vec(vecs[k]);

    // Capture holds after req drops and addr/data change (read, then write).
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h0AB;
    @(posedge fpga_clk);
    #1 cpu_req = 1'b0; cpu_addr = 12'h7FF;
    @(negedge fpga_clk);
    check("hold_rd_addr", {51'b0, cpu_ack, mem_rd_addr}, {51'b0, 1'b1, 12'h0AB});
    @(negedge fpga_clk);
    check("hold_rdata", {55'b0, cpu_rvalid, rdata}, {55'b0, 1'b1, 8'h97});
    @(negedge fpga_clk);
    check("hold_no_regrant", all_outs(), 64'd0);
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 12'h010; dma_wdata = 8'h11;
    @(posedge fpga_clk);
    #1 dma_req = 1'b0; dma_addr = 12'h020; dma_wdata = 8'hEE;
    @(negedge fpga_clk);
    check("hold_wr", {43'b0, mem_wr_go, mem_wr_addr, mem_wr_data}, {43'b0, 1'b1, 12'h010, 8'h11});
    idle_inputs();
    @(negedge fpga_clk);

    // Reset asserted during READ_WAIT discards the read.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h200;
    @(posedge fpga_clk);
    @(posedge fpga_clk);
    #1 rst_in = 1'b1;
    @(negedge fpga_clk);
    check("rst_rw_outputs", all_outs(), 64'd0);
    idle_inputs();
    rst_in = 1'b0;
    @(negedge fpga_clk);
    check("rst_rw_no_rvalid", all_outs(), 64'd0);
    run_vec(vecs[0]);

    // Contention from a fresh reset: both requesters write continuously.
    rst_in = 1'b1;
    @(negedge fpga_clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h300; cpu_wdata = 8'h01;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 12'h301; dma_wdata = 8'h02;
    rst_in = 1'b0;
    ng = 0;
    for (int c = 0; c < 60 && ng < 10; c++) begin
      @(negedge fpga_clk);
      if (cpu_ack || dma_ack) begin
        check("ack_onehot", {62'b0, cpu_ack, dma_ack}, dma_ack ? 64'd1 : 64'd2);
        grants[ng] = dma_ack;
        ng++;
      end
    end
    idle_inputs();
    check("grant_count", 64'(ng), 64'd10);
    for (int g = 0; g < ng; g++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_g = (g % 2 == 1);
`else
      exp_g = (g == 4) || (g == 9);
`endif
      check($sformatf("grant_%0d_is_dma", g), {63'b0, grants[g]}, {63'b0, exp_g});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, memory address width.
REQ-002 SHALL have parameter DATA_W, default 8, memory data width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, lost-arbitration cycles before dma is forced.
REQ-004 SHALL have port fpga_clk  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port rst_in  input  1  asynchronous, active-high reset.
REQ-006 SHALL have ports cpu_req / dma_req  input  1  access request, held until ack.
REQ-007 SHALL have ports cpu_we / dma_we  input  1  1 = write, 0 = read.
REQ-008 SHALL have ports cpu_addr / dma_addr  input  ADDR_W  access address.
REQ-009 SHALL have ports cpu_wdata / dma_wdata  input  DATA_W  write data.
REQ-010 SHALL have ports cpu_ack / dma_ack  output  1  one-cycle grant pulse.
REQ-011 SHALL have ports cpu_rvalid / dma_rvalid  output  1  one-cycle read-data-valid pulse.
REQ-012 SHALL have port rdata  output  DATA_W  read data, shared, qualified by *_rvalid.
REQ-013 SHALL have ports mem_wr_go, mem_wr_addr, mem_wr_data  output  1/ADDR_W/DATA_W  memory write port.
REQ-014 SHALL have ports mem_rd_addr  output  ADDR_W, and mem_rd_data  input  DATA_W, memory read port with 1-cycle synchronous read.

Function
REQ-015 SHALL implement states IDLE, ISSUE, READ_WAIT.
REQ-016 SHALL arbitrate only in IDLE; with any req high, it SHALL capture the winner's we/addr/wdata and go to ISSUE; with none, it SHALL stay in IDLE.
REQ-017 SHALL, in ISSUE, pulse the winner's ack and drive mem_rd_addr/mem_wr_addr from the captured address.
REQ-018 SHALL, in ISSUE for a write, pulse mem_wr_go with the captured data, then return to IDLE (ack at req+1 cycle).
REQ-019 SHALL, in ISSUE for a read, go to READ_WAIT, where it passes mem_rd_data to rdata with the winner's rvalid high, then returns to IDLE (rvalid at req+2 cycles).
REQ-020 SHALL use fixed priority cpu > dma, except as stated in REQ-021.
REQ-021 SHALL count IDLE cycles in which dma_req is high and dma loses; at STARVE_LIMIT dma SHALL win the next arbitration, and the counter SHALL clear on every dma grant.
REQ-022 SHALL complete a granted access with captured values even if the requester drops req or changes addr after the IDLE capture.
REQ-023 SHALL keep mem_wr_go low and both ack/rvalid pairs low outside ISSUE/READ_WAIT; at most one ack and one rvalid SHALL be high in any cycle.
REQ-024 SHALL hold rdata at 0 when no rvalid is high.

Reset
REQ-025 SHALL, on rst_in high at any time, enter IDLE and clear the capture registers, starvation counter and all outputs to 0; an in-flight read SHALL be discarded with no rvalid.
REQ-026 SHALL arbitrate at the first rising edge after rst_in deasserts.

Configuration
REQ-027 SHALL, with MEM_ARB_ROUND_ROBIN_EN defined, replace REQ-020/021 with round-robin: on simultaneous requests the requester not granted last wins (cpu after reset), and the starvation counter is absent.
REQ-028 SHALL, without MEM_ARB_ROUND_ROBIN_EN, implement fixed priority with the starvation counter per REQ-020/021.

Structure
REQ-029 SHALL take the state enum (IDLE/ISSUE/READ_WAIT) and the requester-id enum (REQ_CPU/REQ_DMA) from shared package chip8_pkg.
REQ-030 SHALL be a single module with no sub-modules; the arbitration decision SHALL be an always_comb block inside it.

Verification
REQ-031 Bench: cpu read addr 0x200 with memory 0x200=0xA2 -> cpu_ack at cycle 1, cpu_rvalid and rdata=0xA2 at cycle 2.
REQ-032 Bench: dma write addr 0x050 data 0xF0 -> dma_ack and mem_wr_go at cycle 1 with mem_wr_addr=0x050, mem_wr_data=0xF0.
REQ-033 Bench: cpu_req and dma_req held high, fixed priority, STARVE_LIMIT=4 -> four cpu grants, then one dma grant, then the cycle repeats.
REQ-034 Bench: with MEM_ARB_ROUND_ROBIN_EN, both requesters held high -> grants alternate cpu, dma, cpu, dma.
REQ-035 Bench: rst_in pulsed in READ_WAIT -> no rvalid, all outputs 0, next request served normally.
REQ-036 Bench: cpu drops req and changes addr after the IDLE capture -> access completes to the originally captured address.
